// File: rtl/wall_clk_timer_ctrl.sv
// Interval controller for the wall-clock microsecond counter: clears it on start,
// captures its value on stop/timeout and presents the result over valid/ready.
module wall_clk_timer_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             stop,
    input  logic             timeout_en,
    input  logic [CNT_W-1:0] timeout_val,
    input  logic [CNT_W-1:0] cnt_val,
    output logic             cnt_clear,
    output logic             busy,
    output logic [CNT_W-1:0] elapsed,
    output logic             elapsed_valid,
    input  logic             elapsed_ready,
    output logic             timeout_irq,
    input  logic             irq_ack
);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        RUN,
        REPORT
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_elapsed;
    logic             r_irq;
    logic             w_timeout;
    logic             w_capture;

    assign w_timeout = (r_state == RUN) && timeout_en && (cnt_val >= timeout_val);
    assign w_capture = (r_state == RUN) && (stop || w_timeout);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = CLEAR;
            CLEAR:   w_next = RUN;
            RUN:     if (w_capture) w_next = REPORT;
            REPORT:  if (elapsed_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= IDLE;
            r_elapsed <= '0;
            r_irq     <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_capture)
                r_elapsed <= cnt_val;
            // A timeout in the same cycle as irq_ack keeps the flag set.
            if (w_timeout)
                r_irq <= 1'b1;
            else if (irq_ack)
                r_irq <= 1'b0;
        end
    end

    // Status outputs are pure state decodes, so cnt_clear is glitch-free.
    assign cnt_clear     = (r_state == CLEAR);
    assign busy          = (r_state != IDLE);
    assign elapsed_valid = (r_state == REPORT);
    assign elapsed       = r_elapsed;
    assign timeout_irq   = r_irq;

endmodule

// File: tb/tb_wall_clk_timer_ctrl.sv
// Directed bench for wall_clk_timer_ctrl with a 100-cycle-per-microsecond counter
// model and a scoreboard of expected measurement results.
module tb_wall_clk_timer_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic        stop;
    logic        timeout_en;
    logic [31:0] timeout_val;
    logic [31:0] cnt_val;
    logic        cnt_clear;
    logic        busy;
    logic [31:0] elapsed;
    logic        elapsed_valid;
    logic        elapsed_ready;
    logic        timeout_irq;
    logic        irq_ack;

    typedef struct {
        logic [31:0] el;
        logic        irq;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    logic [6:0] r_pre;

    always #5 clk = ~clk;

    // Wall-clock counter model: one microsecond every 100 clocks, zeroed by cnt_clear.
    always_ff @(posedge clk) begin
        if (!resetn || cnt_clear) begin
            r_pre   <= '0;
            cnt_val <= '0;
        end else if (r_pre == 7'd99) begin
            r_pre   <= '0;
            cnt_val <= cnt_val + 32'd1;
        end else begin
            r_pre <= r_pre + 7'd1;
        end
    end

    wall_clk_timer_ctrl #(.CNT_W(32)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .start        (start),
        .stop         (stop),
        .timeout_en   (timeout_en),
        .timeout_val  (timeout_val),
        .cnt_val      (cnt_val),
        .cnt_clear    (cnt_clear),
        .busy         (busy),
        .elapsed      (elapsed),
        .elapsed_valid(elapsed_valid),
        .elapsed_ready(elapsed_ready),
        .timeout_irq  (timeout_irq),
        .irq_ack      (irq_ack)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_result(input string tag);
        exp_t e;
        n_checks++;
        assert (sb.size() > 0) else begin
            n_errors++;
            $error("FAIL %s_sb: observed=result expected=no result queued", tag);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_valid"},   {31'd0, elapsed_valid}, 32'd1);
            chk({tag, "_elapsed"}, elapsed, e.el);
            chk({tag, "_irq"},     {31'd0, timeout_irq}, {31'd0, e.irq});
        end
    endtask

    // Pulse start from IDLE; returns positioned at the first RUN cycle.
    task automatic begin_meas(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_clear_hi"}, {31'd0, cnt_clear}, 32'd1);
        tick();
        chk({tag, "_clear_lo"}, {31'd0, cnt_clear}, 32'd0);
        chk({tag, "_busy"},     {31'd0, busy}, 32'd1);
    endtask

    // Run k cycles into RUN, then pulse stop; returns in REPORT.
    task automatic run_stop(input string tag, input int k);
        logic saw_clr;
        saw_clr = 1'b0;
        for (int i = 0; i < k; i++) begin
            tick();
            if (cnt_clear) saw_clr = 1'b1;
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk({tag, "_no_extra_clear"}, {31'd0, saw_clr}, 32'd0);
    endtask

    task automatic wait_valid(input string tag, input int budget, output int n);
        n = 0;
        while (!elapsed_valid && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_valid_in_budget"}, {31'd0, elapsed_valid}, 32'd1);
    endtask

    initial begin
        int   n;
        logic bad;
        logic saw_clr;
        logic [31:0] held;

        resetn = 1'b0; start = 1'b0; stop = 1'b0; timeout_en = 1'b0;
        timeout_val = '0; elapsed_ready = 1'b1; irq_ack = 1'b0;
        tick();
        tick();
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_clear", {31'd0, cnt_clear}, 32'd0);
        chk("rst_valid", {31'd0, elapsed_valid}, 32'd0);
        chk("rst_elap",  elapsed, 32'd0);
        chk("rst_irq",   {31'd0, timeout_irq}, 32'd0);
        resetn = 1'b1;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("idle_stop_ignored", {31'd0, busy}, 32'd0);

        // Basic 1000-cycle interval
        sb.push_back('{el: 32'd10, irq: 1'b0});
        begin_meas("t1");
        run_stop("t1", 1000);
        check_result("t1");
        tick();
        chk("t1_valid_drop", {31'd0, elapsed_valid}, 32'd0);
        chk("t1_idle",       {31'd0, busy}, 32'd0);

        // Backpressure with a start pulse during the stall
        elapsed_ready = 1'b0;
        sb.push_back('{el: 32'd10, irq: 1'b0});
        begin_meas("t2");
        run_stop("t2", 1000);
        held = elapsed;
        bad = 1'b0;
        saw_clr = 1'b0;
        for (int i = 0; i < 30; i++) begin
            start = (i == 10);
            tick();
            start = 1'b0;
            if (!elapsed_valid || elapsed !== held) bad = 1'b1;
            if (cnt_clear) saw_clr = 1'b1;
        end
        chk("t2_stable",         {31'd0, bad}, 32'd0);
        chk("t2_start_ignored",  {31'd0, saw_clr}, 32'd0);
        check_result("t2");
        elapsed_ready = 1'b1;
        tick();
        chk("t2_idle",       {31'd0, busy}, 32'd0);
        chk("t2_valid_drop", {31'd0, elapsed_valid}, 32'd0);
        chk("t2_elap_held",  elapsed, 32'd10);

        // Timeout at 5 us
        timeout_en = 1'b1;
        timeout_val = 32'd5;
        sb.push_back('{el: 32'd5, irq: 1'b1});
        begin_meas("t3");
        wait_valid("t3", 700, n);
        chk("t3_latency", n, 32'd501);
        check_result("t3");
        tick();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        chk("t3_irq_ack", {31'd0, timeout_irq}, 32'd0);

        // Stop coincident with timeout at 3 us
        timeout_val = 32'd3;
        sb.push_back('{el: 32'd3, irq: 1'b1});
        begin_meas("t4");
        run_stop("t4", 300);
        check_result("t4");
        tick();
        sb.push_back('{el: 32'd3, irq: 1'b1});
        begin_meas("t4b");
        repeat (300) tick();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        chk("t4b_set_beats_ack", {31'd0, timeout_irq}, 32'd1);
        check_result("t4b");
        tick();

        // Zero threshold
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        chk("t5_irq_cleared", {31'd0, timeout_irq}, 32'd0);
        timeout_val = 32'd0;
        sb.push_back('{el: 32'd0, irq: 1'b1});
        begin_meas("t5");
        wait_valid("t5", 10, n);
        chk("t5_latency", n, 32'd1);
        check_result("t5");
        tick();

        // Reset during RUN abandons the measurement and clears the flag
        timeout_en = 1'b0;
        begin_meas("t6a");
        repeat (50) tick();
        chk("t6_pre_busy", {31'd0, busy}, 32'd1);
        chk("t6_pre_irq",  {31'd0, timeout_irq}, 32'd1);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        chk("t6_busy",  {31'd0, busy}, 32'd0);
        chk("t6_clear", {31'd0, cnt_clear}, 32'd0);
        chk("t6_valid", {31'd0, elapsed_valid}, 32'd0);
        chk("t6_elap",  elapsed, 32'd0);
        chk("t6_irq",   {31'd0, timeout_irq}, 32'd0);
        sb.push_back('{el: 32'd2, irq: 1'b0});
        begin_meas("t6b");
        run_stop("t6b", 200);
        check_result("t6b");
        tick();
        chk("t6b_idle", {31'd0, busy}, 32'd0);

        chk("sb_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/wall_clk_timer_ctrl.md
Name: wall_clk_timer_ctrl

Overview:
Measurement controller that sits directly upstream and downstream of the wall-clock microsecond counter in the custom_cpu wrapper. It drives the counter's clear input and samples its 32-bit count value. It turns start/stop pulses from the wrapper into one timed interval, detects a programmable timeout, and hands the elapsed microseconds to the readout logic over a valid/ready handshake.

Parameters:
- CNT_W, 32, width of counter value, timeout and elapsed fields.

Ports:
- clk  in  1  system clock, 100 MHz.
- resetn  in  1  synchronous, active-low reset.
- start  in  1  single-cycle pulse; begin a measurement.
- stop  in  1  single-cycle pulse; end the measurement.
- timeout_en  in  1  enable timeout detection; sampled every RUN cycle.
- timeout_val  in  CNT_W  timeout threshold in microseconds.
- cnt_val  in  CNT_W  count value from the wall-clock counter.
- cnt_clear  out  1  clear request to the wall-clock counter.
- busy  out  1  measurement in progress or result pending.
- elapsed  out  CNT_W  latched interval in microseconds.
- elapsed_valid  out  1  elapsed holds an unconsumed result.
- elapsed_ready  in  1  consumer accepts the result.
- timeout_irq  out  1  sticky timeout flag.
- irq_ack  in  1  clears timeout_irq.

Behaviour:
- Reset: all outputs 0; state goes to IDLE. Reset is sampled on posedge clk only.
- Reset mid-operation: abandons any run or pending result; timeout_irq is cleared.
- FSM states: IDLE, CLEAR, RUN, REPORT. The state register is updated on posedge clk.
- IDLE:
  - busy=0, cnt_clear=0.
  - start=1 -> CLEAR; stop is ignored.
- CLEAR:
  - cnt_clear=1 for exactly one cycle; busy=1.
  - Unconditionally -> RUN.
  - cnt_clear is a decode of the state register, so it is glitch-free and asserts one cycle after start.
- RUN:
  - busy=1.
  - Timeout condition: timeout_en=1 and cnt_val >= timeout_val (unsigned, full CNT_W compare).
  - If stop=1 or the timeout condition holds: elapsed <= cnt_val, go to REPORT.
  - If the timeout condition holds, also set timeout_irq (including when stop=1 in the same cycle).
  - The first RUN cycle sees cnt_val=0, because the counter zeroed on the CLEAR edge.
  - timeout_val=0 with timeout_en=1 times out on the first RUN cycle with elapsed=0.
- REPORT:
  - busy=1, elapsed_valid=1.
  - elapsed is held stable until elapsed_valid & elapsed_ready; on that handshake -> IDLE, and elapsed_valid drops the next cycle.
  - elapsed keeps its value after the handshake until the next latch.
- start is ignored in CLEAR, RUN and REPORT; no restart and no queuing.
- stop is ignored outside RUN.
- timeout_irq:
  - Set by a RUN timeout; cleared by irq_ack.
  - Set wins over irq_ack in the same cycle.
  - Independent of the FSM after it is set.
- Arithmetic: no subtraction is performed. elapsed equals the cnt_val captured at the stop or timeout cycle, i.e. microseconds since the clear (quantised to 1 µs, truncated).
- cnt_val wrap-around (about 71.6 min) is not detected. The measured interval must stay under 2^32 µs.
- cnt_val is used only in RUN; its value in other states is don't-care.

Test Plan:
1. Basic interval (real wall_clk_counter attached):
   - Stimulus: start at cycle T, elapsed_ready=1, stop at T+1+1+1000 (1000 cycles after RUN entry).
   - Required: cnt_clear high only at cycle T+1; elapsed=10; elapsed_valid high for one cycle; busy low afterwards.
2. Backpressure:
   - Stimulus: as test 1, with elapsed_ready=0 for 30 cycles after REPORT entry, start pulsed during that window, then elapsed_ready=1.
   - Required: elapsed and elapsed_valid stable through the stall; start has no effect (no cnt_clear); IDLE after the handshake.
3. Timeout:
   - Stimulus: timeout_en=1, timeout_val=5, no stop.
   - Required: REPORT entered on the first cycle cnt_val==5 (about 500 cycles into RUN); elapsed=5; timeout_irq=1.
   - Follow-up: irq_ack pulse -> timeout_irq=0 the next cycle.
4. Simultaneous stop and timeout:
   - Stimulus: stop asserted on the cycle cnt_val reaches timeout_val=3.
   - Required: elapsed=3 and timeout_irq=1.
   - Follow-up: irq_ack on the same cycle as a new timeout -> timeout_irq stays 1.
5. Zero threshold:
   - Stimulus: timeout_val=0, timeout_en=1, start.
   - Required: REPORT entered on the cycle after the first RUN cycle; elapsed=0; timeout_irq=1.
6. Reset mid-run:
   - Stimulus: resetn=0 for 1 cycle during RUN, with timeout_irq=1 and busy=1.
   - Required: all outputs 0 on the next cycle.
   - Follow-up: a subsequent start produces a correct measurement (elapsed=2 for 200 RUN cycles).
